// File: rtl/prod_bcd_pkg.sv
// prod_bcd_pkg: shared definitions for the product-to-BCD converter.
//   PBC_BIN_W  default binary input width (multiplier product width)
//   PBC_NDIG   default BCD digit count (10^NDIG > 2^BIN_W)
//   DIG_W      width of one BCD digit
//   PBC_CNT_W  width of the shift-bit counter for the default BIN_W
//   pbc_state_e converter FSM state encoding
package prod_bcd_pkg;

    localparam int PBC_BIN_W = 18;
    localparam int PBC_NDIG  = 6;
    localparam int DIG_W     = 4;
    localparam int PBC_CNT_W = $clog2(PBC_BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } pbc_state_e;

endpackage

// File: rtl/prod_bcd_conv_add3.sv
// bcd_add3: combinational double-dabble digit correction.
//   d_i  in  DIG_W  scratch digit before the shift
//   d_o  out DIG_W  d_i + 3 when d_i >= 5, else d_i (4-bit, no carry out)
module bcd_add3
    import prod_bcd_pkg::*;
(
    input  logic [DIG_W-1:0] d_i,
    output logic [DIG_W-1:0] d_o
);

    assign d_o = (d_i >= DIG_W'(5)) ? d_i + DIG_W'(3) : d_i;

endmodule

// File: rtl/prod_bcd_conv.sv
// prod_bcd_conv: sequential shift-and-add-3 binary to packed BCD converter,
// one input bit per clock, for the multiplier's product display path.
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   start      in   request conversion of bin (sampled in IDLE/DONE only)
//   bin        in   BIN_W unsigned value, captured at the accepted start edge
//   busy       out  high while the conversion is shifting
//   done       out  one-cycle pulse, bcd holds a fresh result
//   bcd        out  packed BCD, digit 0 (units) in [3:0]
//   blank      out  leading-zero blank flags, registered with bcd
//                   (present only when PBC_LZ_BLANK_EN is defined)
//   dbg_state  out  current FSM state
//
// Handshake: start is accepted on a rising edge while the FSM is in IDLE or
// DONE; it is ignored in SHIFT (busy=1), nothing is queued. Exactly BIN_W+1
// edges after the accepting edge, done is high for one cycle and bcd is valid;
// bcd then holds until the next completion. A start seen during the done cycle
// begins the next conversion with no idle gap.
module prod_bcd_conv
    import prod_bcd_pkg::*;
#(
    parameter int BIN_W = PBC_BIN_W,
    parameter int NDIG  = PBC_NDIG
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [DIG_W*NDIG-1:0] bcd,
`ifdef PBC_LZ_BLANK_EN
    output logic [NDIG-1:0]       blank,
`endif
    output pbc_state_e            dbg_state
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = DIG_W * NDIG;

    pbc_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [BIN_W-1:0] shift_q;
    logic [BCD_W-1:0] scratch_q;
    logic             busy_q;
    logic             done_q;
    logic [BCD_W-1:0] bcd_q;

    logic [BCD_W-1:0] corr;
    logic [BCD_W-1:0] scratch_d;
    logic [BIN_W-1:0] shift_d;
    logic [CNT_W-1:0] cnt_d;

    // All digits are corrected in parallel before the shift.
    for (genvar g = 0; g < NDIG; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d_i (scratch_q[g*DIG_W +: DIG_W]),
            .d_o (corr[g*DIG_W +: DIG_W])
        );
    end

    // The top scratch bit falls off the shift; it is always zero for any
    // value that fits in NDIG digits.
    assign scratch_d = BCD_W'({corr, shift_q[BIN_W-1]});
    assign shift_d   = {shift_q[BIN_W-2:0], 1'b0};
    assign cnt_d     = cnt_q + CNT_W'(1);

`ifdef PBC_LZ_BLANK_EN
    logic [NDIG-1:0] blank_q;
    logic [NDIG-1:0] blank_d;
    logic            all_zero;

    // Digit i blanks when it and every higher digit are zero; digit 0 never
    // blanks so a zero result still shows one "0".
    always_comb begin
        blank_d  = '0;
        all_zero = 1'b1;
        for (int i = NDIG - 1; i >= 1; i--) begin
            if (scratch_q[i*DIG_W +: DIG_W] != '0) begin
                all_zero = 1'b0;
            end
            blank_d[i] = all_zero;
        end
    end

    assign blank = blank_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            scratch_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
`ifdef PBC_LZ_BLANK_EN
            blank_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q   <= SHIFT;
                        shift_q   <= bin;
                        scratch_q <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                SHIFT: begin
                    // The completion edge does no shifting: it only publishes
                    // the scratch, giving the BIN_W+1 edge latency.
                    if (cnt_q == CNT_W'(BIN_W)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        bcd_q   <= scratch_q;
`ifdef PBC_LZ_BLANK_EN
                        blank_q <= blank_d;
`endif
                    end else begin
                        scratch_q <= scratch_d;
                        shift_q   <= shift_d;
                        cnt_q     <= cnt_d;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q   <= SHIFT;
                        shift_q   <= bin;
                        scratch_q <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign bcd       = bcd_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_prod_bcd_conv.sv
// tb_prod_bcd_conv: directed bench for prod_bcd_conv with hand-computed
// packed BCD results. Build with +define+PBC_LZ_BLANK_EN to also cover the
// leading-zero blank flags.
module tb_prod_bcd_conv;
    import prod_bcd_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [17:0] bin;
    logic        busy;
    logic        done;
    logic [23:0] bcd;
`ifdef PBC_LZ_BLANK_EN
    logic [5:0]  blank;
`endif
    pbc_state_e  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [23:0] exp_q[$];

    prod_bcd_conv dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bin       (bin),
        .busy      (busy),
        .done      (done),
        .bcd       (bcd),
`ifdef PBC_LZ_BLANK_EN
        .blank     (blank),
`endif
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for done; n0 is the number of edges already elapsed since the
    // accepting edge. held is the bcd value that must persist while busy.
    task automatic wait_result(input string tag, input int n0,
                               input logic [23:0] held);
        int n;
        logic [23:0] e;
        n = n0;
        e = exp_q.pop_front();
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
            if (n == 10) begin
                check_eq({tag, " busy mid"}, 32'(busy), 32'd1);
                check_eq({tag, " bcd held"}, 32'(bcd), 32'(held));
            end
        end
        check_eq({tag, " latency"}, 32'(n), 32'd19);
        check_eq({tag, " bcd"}, 32'(bcd), 32'(e));
        check_eq({tag, " busy at done"}, 32'(busy), 32'd0);
    endtask

    task automatic run_conv(input string tag, input logic [17:0] val,
                            input logic [23:0] exp, input logic [23:0] held);
        bin = val;
        exp_q.push_back(exp);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq({tag, " busy after start"}, 32'(busy), 32'd1);
        check_eq({tag, " done after start"}, 32'(done), 32'd0);
        wait_result(tag, 0, held);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) tick();
        check_eq("rst busy", 32'(busy), 32'd0);
        check_eq("rst done", 32'(done), 32'd0);
        check_eq("rst bcd", 32'(bcd), 32'd0);
        check_eq("rst state", 32'(dbg_state), 32'd0);
`ifdef PBC_LZ_BLANK_EN
        check_eq("rst blank", 32'(blank), 32'd0);
`endif
        reset = 1'b0;
        tick();

        // 25*20
        run_conv("t1", 18'd500, 24'h000500, 24'h000000);
        tick();
        check_eq("t1 done pulse", 32'(done), 32'd0);
        check_eq("t1 idle", 32'(dbg_state), 32'd0);

        // 24*26 then 511*511, second start during the done cycle
        run_conv("t2a", 18'd624, 24'h000624, 24'h000500);
        run_conv("t2b", 18'd261121, 24'h261121, 24'h000624);
        tick();
        check_eq("t2 done pulse", 32'(done), 32'd0);

        // zero and 6*23
        run_conv("t3a", 18'd0, 24'h000000, 24'h261121);
`ifdef PBC_LZ_BLANK_EN
        check_eq("t3a blank", 32'(blank), 32'b111110);
`endif
        tick();
        run_conv("t3b", 18'd138, 24'h000138, 24'h000000);
`ifdef PBC_LZ_BLANK_EN
        check_eq("t3b blank", 32'(blank), 32'b111000);
`endif
        tick();

        // start pulsed mid-conversion must be ignored
        bin = 18'd77;
        exp_q.push_back(24'h000077);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        bin = 18'd1419;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_result("t4", 6, 24'h000138);
        tick();
        check_eq("t4 done pulse", 32'(done), 32'd0);
        check_eq("t4 busy low", 32'(busy), 32'd0);
        repeat (3) tick();
        check_eq("t4 no queued busy", 32'(busy), 32'd0);
        check_eq("t4 result kept", 32'(bcd), 32'h000077);

        // asynchronous abort 8 cycles into 341*345
        bin = 18'd117645;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        #2 reset = 1'b1;
        #1;
        check_eq("t5 abort busy", 32'(busy), 32'd0);
        check_eq("t5 abort done", 32'(done), 32'd0);
        check_eq("t5 abort bcd", 32'(bcd), 32'd0);
        check_eq("t5 abort state", 32'(dbg_state), 32'd0);
        #3 reset = 1'b0;
        tick();
        run_conv("t5", 18'd117645, 24'h117645, 24'h000000);
        tick();

        // bin changes right after the accepting edge
        bin = 18'd12345;
        exp_q.push_back(24'h012345);
        start = 1'b1;
        tick();
        start = 1'b0;
        bin = 18'd262143;
        wait_result("t6", 0, 24'h117645);
        tick();

        // full-scale input
        run_conv("t7", 18'd262143, 24'h262143, 24'h012345);
        tick();

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
